// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the pipelined RISC-V core front end.
//   if_state_t        : instruction-fetch FSM state encoding
//   NOP_INSTR         : canonical bubble instruction (addi x0,x0,0)
//   RESET_PC_DEFAULT  : default architectural PC after reset
//   word_align()      : forces a byte address onto a 4-byte boundary
// -----------------------------------------------------------------------------
package core_pkg;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    FULL  = 3'd3,
    DROP  = 3'd4
  } if_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Masking (rather than slicing) keeps every input bit referenced.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register. Update priority: flush > stall > load > bubble.
// A flush or bubble clears valid and inserts NOP_INSTR; the PC field is left
// untouched in those cases.
// Ports:
//   clk, rstn          clock, async active-low reset
//   flush, stall       hazard-unit controls
//   load               a fetched instruction is being delivered this cycle
//   load_pc/load_instr PC and instruction word being delivered
//   valid, pc, instr   registered IF/ID contents
// -----------------------------------------------------------------------------
module if_id_reg
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        stall,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  // IF/ID register update with flush > stall > load > bubble priority
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= 1'b0;
      pc    <= 32'h0000_0000;
      instr <= NOP_INSTR;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (stall) begin
      valid <= valid;
      pc    <= pc;
      instr <= instr;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end else begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end
  end

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage: architectural PC, single-outstanding imem read
// sequencing, one-entry skid buffer for responses that arrive under stall,
// and the IF/ID pipeline register.
// Ports:
//   clk, rstn              clock, async active-low reset
//   redirect, redirect_pc  PCSrc / target from next-PC logic (bits [1:0] ignored)
//   stall, flush           hazard-unit controls for IF/ID and PC
//   imem_req, imem_addr    registered read request and word address (= pc)
//   imem_rvalid/rdata      read response (one request in flight at most)
//   if_pc                  current PC register, fed to next-PC logic
//   id_valid/id_pc/id_instr IF/ID register contents
// -----------------------------------------------------------------------------
module if_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr
);

  if_state_t   state;
  if_state_t   state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] skid;
  logic [31:0] skid_next;
  logic [31:0] target;
  logic        deliver;
  logic [31:0] deliver_instr;
  logic        req;

  assign target = word_align(redirect_pc);

  // Next-state, next-PC and delivery decode; redirect always beats delivery
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    skid_next     = skid;
    deliver       = 1'b0;
    deliver_instr = skid;
    case (state)
      BOOT: begin
        state_next = FETCH;
      end
      FETCH: begin
        // A response here would be a protocol error and is ignored.
        if (redirect) begin
          pc_next    = target;
          state_next = DROP;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_next = target;
          // If the response lands together with the redirect it is simply
          // discarded; otherwise it is still in flight and must be dropped.
          if (imem_rvalid) begin
            state_next = FETCH;
          end else begin
            state_next = DROP;
          end
        end else if (imem_rvalid && !stall) begin
          deliver       = 1'b1;
          deliver_instr = imem_rdata;
          pc_next       = pc + 32'd4;
          state_next    = FETCH;
        end else if (imem_rvalid) begin
          skid_next  = imem_rdata;
          state_next = FULL;
        end else begin
          state_next = WAIT;
        end
      end
      FULL: begin
        if (redirect) begin
          pc_next    = target;
          state_next = FETCH;
        end else if (!stall) begin
          deliver       = 1'b1;
          deliver_instr = skid;
          pc_next       = pc + 32'd4;
          state_next    = FETCH;
        end else begin
          state_next = FULL;
        end
      end
      DROP: begin
        if (redirect) begin
          pc_next = target;
        end else begin
          pc_next = pc;
        end
        if (imem_rvalid) begin
          state_next = FETCH;
        end else begin
          state_next = DROP;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  // FSM state, PC, skid buffer and registered read request
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= BOOT;
      pc    <= RESET_PC;
      skid  <= NOP_INSTR;
      req   <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      skid  <= skid_next;
      // Registered decode of the state being entered, so imem_req is a
      // flop output equal to (state == FETCH) with no input-to-output path.
      req   <= (state_next == FETCH);
    end
  end

  assign imem_req  = req;
  assign imem_addr = pc;
  assign if_pc     = pc;

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .stall      (stall),
    .load       (deliver),
    .load_pc    (pc),
    .load_instr (deliver_instr),
    .valid      (id_valid),
    .pc         (id_pc),
    .instr      (id_instr)
  );

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Directed bench for if_stage. Two instances share all inputs: dut0 uses the
// default reset PC, dut1 resets to 32'hFFFF_FFFC to exercise PC wrap. Because
// their FSMs see identical inputs, their request timing is identical and only
// the addresses differ.
// -----------------------------------------------------------------------------
module tb_if_stage;
  import core_pkg::*;

  logic        clk;
  logic        rstn;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        flush;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        req0, req1;
  logic [31:0] addr0, addr1;
  logic [31:0] ifpc0, ifpc1;
  logic        idv0, idv1;
  logic [31:0] idpc0, idpc1;
  logic [31:0] idin0, idin1;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] I0  = 32'h0010_0093;
  localparam logic [31:0] I1  = 32'h0020_0113;
  localparam logic [31:0] I2  = 32'h0030_0193;
  localparam logic [31:0] I3  = 32'h0040_0213;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  if_stage dut0 (
    .clk(clk), .rstn(rstn), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .flush(flush), .imem_req(req0), .imem_addr(addr0),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_pc(ifpc0),
    .id_valid(idv0), .id_pc(idpc0), .id_instr(idin0)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rstn(rstn), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .flush(flush), .imem_req(req1), .imem_addr(addr1),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_pc(ifpc1),
    .id_valid(idv1), .id_pc(idpc1), .id_instr(idin1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // advance one clock edge and settle just after it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    stall       = 1'b0;
    flush       = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;

    cyc();
    cyc();
    // reset state
    check_eq("rst_req",    {31'd0, req0}, 32'd0);
    check_eq("rst_valid",  {31'd0, idv0}, 32'd0);
    check_eq("rst_id_pc",  idpc0, 32'h0);
    check_eq("rst_instr",  idin0, NOP_INSTR);
    check_eq("rst_pc0",    ifpc0, 32'h0);
    check_eq("rst_pc1",    ifpc1, 32'hFFFF_FFFC);

    rstn = 1'b1;
    cyc();  // BOOT -> FETCH
    check_eq("f0_req",   {31'd0, req0}, 32'd1);
    check_eq("f0_addr",  addr0, 32'h0);
    check_eq("f0_addr1", addr1, 32'hFFFF_FFFC);
    cyc();  // FETCH -> WAIT
    check_eq("w0_req",   {31'd0, req0}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = I0;
    cyc();  // delivery of I0
    imem_rvalid = 1'b0;
    check_eq("d0_valid", {31'd0, idv0}, 32'd1);
    check_eq("d0_pc",    idpc0, 32'h0);
    check_eq("d0_instr", idin0, I0);
    check_eq("f1_addr",  addr0, 32'h4);
    check_eq("f1_addr1", addr1, 32'h0);
    cyc();  // WAIT, bubble
    check_eq("b1_valid", {31'd0, idv0}, 32'd0);
    check_eq("b1_instr", idin0, NOP_INSTR);
    imem_rvalid = 1'b1; imem_rdata = I1;
    cyc();
    imem_rvalid = 1'b0;
    check_eq("d1_valid", {31'd0, idv0}, 32'd1);
    check_eq("d1_pc",    idpc0, 32'h4);
    check_eq("d1_instr", idin0, I1);
    check_eq("f2_addr",  addr0, 32'h8);
    check_eq("f2_addr1", addr1, 32'h4);
    cyc();  // WAIT for PC 8

    // response arrives under stall, stall held 3 cycles
    imem_rvalid = 1'b1; imem_rdata = I2; stall = 1'b1;
    cyc();
    imem_rvalid = 1'b0;
    check_eq("s_valid",  {31'd0, idv0}, 32'd0);
    check_eq("s_id_pc",  idpc0, 32'h4);
    check_eq("s_req",    {31'd0, req0}, 32'd0);
    cyc();
    check_eq("s_pc",     ifpc0, 32'h8);
    check_eq("s_instr",  idin0, NOP_INSTR);
    cyc();
    stall = 1'b0;
    cyc();
    check_eq("sk_valid", {31'd0, idv0}, 32'd1);
    check_eq("sk_pc",    idpc0, 32'h8);
    check_eq("sk_instr", idin0, I2);
    check_eq("sk_addr",  addr0, 32'hC);
    check_eq("sk_req",   {31'd0, req0}, 32'd1);

    // flush wins over stall
    flush = 1'b1; stall = 1'b1;
    cyc();
    flush = 1'b0; stall = 1'b0;
    check_eq("fl_valid", {31'd0, idv0}, 32'd0);
    check_eq("fl_instr", idin0, 32'h0000_0013);

    // redirect in WAIT, stale response two cycles later
    redirect = 1'b1; redirect_pc = 32'h100;
    cyc();
    redirect = 1'b0;
    check_eq("rd_pc",    ifpc0, 32'h100);
    check_eq("rd_req",   {31'd0, req0}, 32'd0);
    cyc();
    check_eq("rd_req2",  {31'd0, req0}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = BAD;
    cyc();
    imem_rvalid = 1'b0;
    check_eq("dr_valid", {31'd0, idv0}, 32'd0);
    check_eq("dr_req",   {31'd0, req0}, 32'd1);
    check_eq("dr_addr",  addr0, 32'h100);
    cyc();  // WAIT

    // redirect coincident with rvalid: no DROP
    redirect = 1'b1; redirect_pc = 32'h200; imem_rvalid = 1'b1; imem_rdata = BAD;
    cyc();
    redirect = 1'b0; imem_rvalid = 1'b0;
    check_eq("rc_req",   {31'd0, req0}, 32'd1);
    check_eq("rc_addr",  addr0, 32'h200);
    check_eq("rc_valid", {31'd0, idv0}, 32'd0);
    cyc();  // WAIT

    // misaligned redirect target
    redirect = 1'b1; redirect_pc = 32'h103; imem_rvalid = 1'b1; imem_rdata = BAD;
    cyc();
    redirect = 1'b0; imem_rvalid = 1'b0;
    check_eq("al_addr",  addr0, 32'h100);
    check_eq("al_addr1", addr1, 32'h100);
    cyc();
    imem_rvalid = 1'b1; imem_rdata = I3;
    cyc();
    imem_rvalid = 1'b0;
    check_eq("d3_pc",    idpc0, 32'h100);
    check_eq("d3_instr", idin0, I3);
    check_eq("d3_addr",  addr0, 32'h104);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
